level_ctrl_fsm: RTL and testbench
=================================

// Module: level_ctrl_fsm
// PURPOSE
//  Parametrised game-level controller for the brick-breaker core. Tracks current level,
//  lives and special-block state. Turns debounced level buttons, board-clear and ball-loss
//  into committed level changes, each followed by a timed active-low game reset pulse (oRST)
//  to the ball/slider/block logic. Fully synchronous to iCLK; no derived-clock logic.
// PARAMETERS
//  NUM_LEVELS    3       number of levels, valid oLevel 0..NUM_LEVELS-1
//  LVL_W         2       oLevel width, >= clog2(NUM_LEVELS)
//  BLOCKS        300     width of iState_flag (one bit per live block)
//  LIVES         3       lives loaded at reset / restart, 1..15
//  DEBOUNCE_CYC  5000    cycles a button must be stable before its debounced value changes
//  HOLD_CYC      100000  cycles an event must persist before it is committed
//  PULSE_CYC     16      oRST low time after a commit, cycles
// PORTS
//  iCLK               in   1       system clock
//  iRST               in   1       async active-low reset, whole block
//  iLevel_Up          in   1       level-up button, active-low, asynchronous
//  iLevel_Down        in   1       level-down button, active-low, asynchronous
//  iState_flag        in   BLOCKS  block-alive bits; all-zero = board cleared
//  iBallDie           in   1       ball lost, level signal from ball logic
//  iSpecial_attacked  in   1       special block hit this cycle
//  oLevel             out  LVL_W   current level
//  oSlider_flag       out  2       2'b00 at level 0, 2'b11 at any level > 0
//  oSpecial_block     out  1       1 = special block present
//  oRST               out  1       active-low game reset to playfield logic
//  oLives             out  4       remaining lives
//  oGameOver          out  1       1 while in GAME_OVER
//  oCommit            out  1       one-cycle pulse on each committed action
// BEHAVIOUR
//  Reset (iRST=0, async): oLevel=0, oSlider_flag=00, oSpecial_block=1, oRST=1, oLives=LIVES,
//   oGameOver=0, oCommit=0, FSM=PLAY, all counters 0, debounced buttons = released (1).
//  Buttons: 2-FF synchroniser, then debounce counter; debounced value changes only after
//   DEBOUNCE_CYC consecutive cycles of a differing synchronised value. Press = debounced 0.
//  Event priority, sampled each cycle in PLAY: UP > DOWN > CLEAR (iState_flag==0) > DIE.
//  FSM states PLAY, HOLD, PULSE, GAME_OVER:
//   PLAY: any event -> HOLD, latch the winning cause, hold counter=1.
//   HOLD: latched cause still true -> counter+1; cause false -> PLAY, counter=0.
//    Counter reaching HOLD_CYC -> apply action, oCommit=1 for one cycle, -> PULSE.
//    A higher-priority event arriving in HOLD does not replace the latched cause.
//   PULSE: oRST=0 for exactly PULSE_CYC cycles (first low cycle = cycle after commit),
//    then oRST=1 and -> PLAY, or -> GAME_OVER if oLives==0. Events ignored during PULSE.
//    After PULSE, a still-held cause must be released and re-asserted to act again.
//   GAME_OVER: oGameOver=1; only UP or DOWN presses count; after HOLD_CYC press:
//    oLevel=0, oLives=LIVES, -> PULSE. CLEAR/DIE ignored.
//  Actions: UP: oLevel+1, saturate at NUM_LEVELS-1 (pulse still issued).
//   DOWN: oLevel-1, saturate at 0. CLEAR: oLevel+1 if < NUM_LEVELS-1, else stay and
//   oLives=LIVES. DIE: oLives-1 (saturate at 0); level unchanged.
//  oSlider_flag derived from the registered oLevel, same cycle as the level update.
//  oSpecial_block: iSpecial_attacked=1 -> 0 next cycle, in any state; set to 1 on every
//   commit. Same-cycle attack and commit -> commit wins (1).
//  Reset asserted mid-HOLD or mid-PULSE: immediate return to reset values, oRST=1.
// TESTING (bench params: DEBOUNCE_CYC=4, HOLD_CYC=8, PULSE_CYC=4, NUM_LEVELS=3, LIVES=3)
//  Hold iLevel_Up low 20 cycles from level 0 -> oLevel=1, oSlider_flag=11, one oCommit,
//   oRST low 4 cycles; releasing and repeating twice -> oLevel stops at 2.
//  iLevel_Up glitches low 2 cycles, or low 6 cycles total -> no commit, oLevel unchanged.
//  iState_flag=0 for 8+ cycles at level 2 -> oLevel stays 2, oLives reloads to 3, one pulse.
//  Three held iBallDie events -> oLives 2,1,0; after 3rd pulse oGameOver=1; held iBallDie
//   then no effect; iLevel_Down held -> oLevel=0, oLives=3, oGameOver=0 after pulse.
//  iSpecial_attacked in PLAY -> oSpecial_block=0; stays 0 until next commit, then 1.
//  iRST low during PULSE cycle 2 -> oRST=1, oLevel=0, oLives=3 immediately.

Source files
------------

// File: rtl/level_ctrl_fsm.sv
// level_ctrl_fsm
//   Game-level controller for the brick-breaker core. It watches the level
//   buttons, the board-clear condition and ball loss. An event is committed
//   only after it has persisted for HOLD_CYC cycles. Each commit is followed
//   by an active-low playfield reset pulse (oRST) that lasts PULSE_CYC cycles.
//
// Ports
//   iCLK, iRST          clock, async active-low reset
//   iLevel_Up/Down      raw active-low buttons (synchronised + debounced here)
//   iState_flag         block-alive bits, all zero = board cleared
//   iBallDie            ball lost
//   iSpecial_attacked   special block hit this cycle
//   oLevel              current level
//   oSlider_flag        00 at level 0, 11 otherwise
//   oSpecial_block      special block present
//   oRST                active-low playfield reset
//   oLives              remaining lives
//   oGameOver           high in GAME_OVER
//   oCommit             one-cycle pulse per committed action
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_PLAY      | idle, waiting for an event
// S_HOLD      | event latched, counting how long it persists
// S_PULSE     | action applied, oRST held low
// S_GAME_OVER | no lives left, only a held UP/DOWN press restarts the game
module level_ctrl_fsm #(
   parameter int NUM_LEVELS   = 3,
   parameter int LVL_W        = 2,
   parameter int BLOCKS       = 300,
   parameter int LIVES        = 3,
   parameter int DEBOUNCE_CYC = 5000,
   parameter int HOLD_CYC     = 100000,
   parameter int PULSE_CYC    = 16
) (
   input  logic              iCLK,
   input  logic              iRST,
   input  logic              iLevel_Up,
   input  logic              iLevel_Down,
   input  logic [BLOCKS-1:0] iState_flag,
   input  logic              iBallDie,
   input  logic              iSpecial_attacked,
   output logic [LVL_W-1:0]  oLevel,
   output logic [1:0]        oSlider_flag,
   output logic              oSpecial_block,
   output logic              oRST,
   output logic [3:0]        oLives,
   output logic              oGameOver,
   output logic              oCommit
);

   localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam int HC_W = $clog2(HOLD_CYC + 1);
   localparam int PC_W = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;

   localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYC - 1);
   localparam logic [HC_W-1:0]  HOLD_LAST  = HC_W'(HOLD_CYC - 1);
   localparam logic [PC_W-1:0]  PULSE_LAST = PC_W'(PULSE_CYC - 1);
   localparam logic [LVL_W-1:0] LVL_MAX    = LVL_W'(NUM_LEVELS - 1);
   localparam logic [3:0]       LIVES_INIT = 4'(LIVES);

   typedef enum logic [1:0] {S_PLAY, S_HOLD, S_PULSE, S_GAME_OVER} state_t;
   typedef enum logic [1:0] {C_UP, C_DOWN, C_CLEAR, C_DIE} cause_t;

   // ---------------- button synchroniser + debounce ----------------
   // index 0 = up, 1 = down; all values active-low
   logic [1:0]      sync1_q, sync2_q, deb_q;
   logic [DB_W-1:0] db_cnt_q [2];

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         sync1_q <= 2'b11;
         sync2_q <= 2'b11;
         deb_q   <= 2'b11;
         for (int b = 0; b < 2; b++) db_cnt_q[b] <= '0;
      end else begin
         sync1_q <= {iLevel_Down, iLevel_Up};
         sync2_q <= sync1_q;
         for (int b = 0; b < 2; b++) begin
            if (sync2_q[b] == deb_q[b]) begin
               db_cnt_q[b] <= '0;
            end else if (db_cnt_q[b] == DB_LAST) begin
               deb_q[b]    <= sync2_q[b];
               db_cnt_q[b] <= '0;
            end else begin
               db_cnt_q[b] <= db_cnt_q[b] + 1'b1;
            end
         end
      end
   end

   // ---------------- main FSM ----------------
   state_t           state_q, state_d;
   cause_t           cause_q, cause_d;
   logic             from_go_q, from_go_d;
   logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
   logic [PC_W-1:0]  pulse_cnt_q, pulse_cnt_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic [3:0]       lives_q, lives_d;
   logic             special_q, special_d;
   logic             rst_q, rst_d;
   logic             commit_q, commit_d;
   logic [3:0]       block_q, block_d;
   logic [3:0]       ev_raw, ev;

   always_comb begin
      ev_raw          = '0;
      ev_raw[C_UP]    = ~deb_q[0];
      ev_raw[C_DOWN]  = ~deb_q[1];
      ev_raw[C_CLEAR] = (iState_flag == '0);
      ev_raw[C_DIE]   = iBallDie;
   end

   // A committed cause stays blocked until it is seen released.
   assign ev = ev_raw & ~block_q;

   always_comb begin
      state_d     = state_q;
      cause_d     = cause_q;
      from_go_d   = from_go_q;
      hold_cnt_d  = hold_cnt_q;
      pulse_cnt_d = pulse_cnt_q;
      level_d     = level_q;
      lives_d     = lives_q;
      rst_d       = rst_q;
      commit_d    = 1'b0;
      block_d     = block_q & ev_raw;

      unique case (state_q)
         S_PLAY: begin
            if (|ev) begin
               state_d    = S_HOLD;
               hold_cnt_d = HC_W'(1);
               from_go_d  = 1'b0;
               cause_d    = ev[C_UP]    ? C_UP    :
                            ev[C_DOWN]  ? C_DOWN  :
                            ev[C_CLEAR] ? C_CLEAR : C_DIE;
            end
         end
         S_GAME_OVER: begin
            if (ev[C_UP] || ev[C_DOWN]) begin
               state_d    = S_HOLD;
               hold_cnt_d = HC_W'(1);
               from_go_d  = 1'b1;
               cause_d    = ev[C_UP] ? C_UP : C_DOWN;
            end
         end
         S_HOLD: begin
            if (ev_raw[cause_q]) begin
               if (hold_cnt_q == HOLD_LAST) commit_d = 1'b1;
               else                         hold_cnt_d = hold_cnt_q + 1'b1;
            end else begin
               state_d    = from_go_q ? S_GAME_OVER : S_PLAY;
               hold_cnt_d = '0;
            end
         end
         S_PULSE: begin
            if (pulse_cnt_q == '0) begin
               rst_d   = 1'b1;
               state_d = (lives_q == '0) ? S_GAME_OVER : S_PLAY;
            end else begin
               pulse_cnt_d = pulse_cnt_q - 1'b1;
            end
         end
         default: state_d = S_PLAY;
      endcase

      if (commit_d) begin
         state_d          = S_PULSE;
         hold_cnt_d       = '0;
         pulse_cnt_d      = PULSE_LAST;
         rst_d            = 1'b0;
         block_d[cause_q] = 1'b1;
         if (from_go_q) begin
            level_d = '0;
            lives_d = LIVES_INIT;
         end else begin
            unique case (cause_q)
               C_UP:    if (level_q < LVL_MAX) level_d = level_q + 1'b1;
               C_DOWN:  if (level_q != '0)     level_d = level_q - 1'b1;
               C_CLEAR: if (level_q < LVL_MAX) level_d = level_q + 1'b1;
                        else                   lives_d = LIVES_INIT;
               C_DIE:   if (lives_q != '0)     lives_d = lives_q - 1'b1;
               default: ;
            endcase
         end
      end

      // a commit on the same cycle as an attack restores the block
      special_d = commit_d ? 1'b1 : (iSpecial_attacked ? 1'b0 : special_q);
   end

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         state_q     <= S_PLAY;
         cause_q     <= C_UP;
         from_go_q   <= 1'b0;
         hold_cnt_q  <= '0;
         pulse_cnt_q <= '0;
         level_q     <= '0;
         lives_q     <= LIVES_INIT;
         special_q   <= 1'b1;
         rst_q       <= 1'b1;
         commit_q    <= 1'b0;
         block_q     <= '0;
      end else begin
         state_q     <= state_d;
         cause_q     <= cause_d;
         from_go_q   <= from_go_d;
         hold_cnt_q  <= hold_cnt_d;
         pulse_cnt_q <= pulse_cnt_d;
         level_q     <= level_d;
         lives_q     <= lives_d;
         special_q   <= special_d;
         rst_q       <= rst_d;
         commit_q    <= commit_d;
         block_q     <= block_d;
      end
   end

   assign oLevel         = level_q;
   assign oSlider_flag   = (level_q != '0) ? 2'b11 : 2'b00;
   assign oSpecial_block = special_q;
   assign oRST           = rst_q;
   assign oLives         = lives_q;
   assign oGameOver      = (state_q == S_GAME_OVER);
   assign oCommit        = commit_q;

endmodule

// File: tb/tb_level_ctrl_fsm.sv
module tb_level_ctrl_fsm;

   localparam int BLK = 16;

   logic           iCLK = 1'b0;
   logic           iRST;
   logic           iLevel_Up, iLevel_Down;
   logic [BLK-1:0] iState_flag;
   logic           iBallDie, iSpecial_attacked;
   logic [1:0]     oLevel;
   logic [1:0]     oSlider_flag;
   logic           oSpecial_block, oRST, oGameOver, oCommit;
   logic [3:0]     oLives;

   level_ctrl_fsm #(
      .NUM_LEVELS(3), .LVL_W(2), .BLOCKS(BLK), .LIVES(3),
      .DEBOUNCE_CYC(4), .HOLD_CYC(8), .PULSE_CYC(4)
   ) dut (
      .iCLK(iCLK), .iRST(iRST),
      .iLevel_Up(iLevel_Up), .iLevel_Down(iLevel_Down),
      .iState_flag(iState_flag), .iBallDie(iBallDie),
      .iSpecial_attacked(iSpecial_attacked),
      .oLevel(oLevel), .oSlider_flag(oSlider_flag),
      .oSpecial_block(oSpecial_block), .oRST(oRST), .oLives(oLives),
      .oGameOver(oGameOver), .oCommit(oCommit)
   );

   always #5 iCLK = ~iCLK;

   typedef struct {
      bit up, down, clr, die, atk;
      int ncyc;
      int lvl, lives, go, sp, commits, lows;
   } vec_t;

   vec_t tbl [16];
   int   checks = 0;
   int   errors = 0;
   int   n_commit, n_low;
   bit   seen;

   function automatic vec_t mk(bit u, bit d, bit c, bit di, bit a, int n,
                               int lvl, int lv, int go, int sp, int cm, int lo);
      vec_t v;
      v.up = u; v.down = d; v.clr = c; v.die = di; v.atk = a; v.ncyc = n;
      v.lvl = lvl; v.lives = lv; v.go = go; v.sp = sp; v.commits = cm; v.lows = lo;
      return v;
   endfunction

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(int n);
      repeat (n) begin
         @(negedge iCLK);
         if (oCommit) n_commit++;
         if (!oRST)   n_low++;
      end
   endtask

   task automatic drive(bit u, bit d, bit c, bit di, bit a);
      iLevel_Up         = ~u;
      iLevel_Down       = ~d;
      iState_flag       = c ? '0 : '1;
      iBallDie          = di;
      iSpecial_attacked = a;
   endtask

   task automatic wait_commit(output bit s);
      s = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge iCLK);
         if (oCommit) begin
            s = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      //            up dn cl di at  n   lvl lv go sp cm lo
      tbl[0]  = mk(1, 0, 0, 0, 0, 20,  1, 3, 0, 1, 1, 4);
      tbl[1]  = mk(1, 0, 0, 0, 0, 20,  2, 3, 0, 1, 1, 4);
      tbl[2]  = mk(1, 0, 0, 0, 0, 20,  2, 3, 0, 1, 1, 4); // saturates, pulse still issued
      tbl[3]  = mk(1, 0, 0, 0, 0,  2,  2, 3, 0, 1, 0, 0); // glitch
      tbl[4]  = mk(1, 0, 0, 0, 0,  6,  2, 3, 0, 1, 0, 0); // too short to commit
      tbl[5]  = mk(0, 0, 1, 1, 0, 10,  2, 3, 0, 1, 1, 4); // clear outranks die
      tbl[6]  = mk(0, 0, 0, 1, 0, 12,  2, 2, 0, 1, 1, 4);
      tbl[7]  = mk(0, 0, 1, 0, 0, 10,  2, 3, 0, 1, 1, 4); // clear at top reloads lives
      tbl[8]  = mk(0, 0, 0, 0, 1,  1,  2, 3, 0, 0, 0, 0); // special hit
      tbl[9]  = mk(0, 0, 0, 1, 0, 12,  2, 2, 0, 1, 1, 4);
      tbl[10] = mk(0, 0, 0, 1, 0, 12,  2, 1, 0, 1, 1, 4);
      tbl[11] = mk(0, 0, 0, 1, 0, 12,  2, 0, 1, 1, 1, 4);
      tbl[12] = mk(0, 0, 0, 1, 0, 12,  2, 0, 1, 1, 0, 0); // ignored in game over
      tbl[13] = mk(0, 0, 1, 0, 0, 12,  2, 0, 1, 1, 0, 0);
      tbl[14] = mk(0, 1, 0, 0, 0, 20,  0, 3, 0, 1, 1, 4); // restart
      tbl[15] = mk(0, 1, 0, 0, 0, 20,  0, 3, 0, 1, 1, 4); // saturates at 0

      drive(0, 0, 0, 0, 0);
      iRST = 1'b0;
      repeat (3) @(negedge iCLK);
      chk("reset level",   oLevel, 0);
      chk("reset slider",  oSlider_flag, 0);
      chk("reset special", oSpecial_block, 1);
      chk("reset orst",    oRST, 1);
      chk("reset lives",   oLives, 3);
      chk("reset gameover", oGameOver, 0);
      chk("reset commit",  oCommit, 0);
      iRST = 1'b1;
      @(negedge iCLK);

      for (int i = 0; i < 16; i++) begin
         n_commit = 0;
         n_low    = 0;
         drive(tbl[i].up, tbl[i].down, tbl[i].clr, tbl[i].die, tbl[i].atk);
         tick(tbl[i].ncyc);
         drive(0, 0, 0, 0, 0);
         tick(25);
         chk($sformatf("row%0d level", i),    oLevel, tbl[i].lvl);
         chk($sformatf("row%0d slider", i),   oSlider_flag, (tbl[i].lvl != 0) ? 3 : 0);
         chk($sformatf("row%0d lives", i),    oLives, tbl[i].lives);
         chk($sformatf("row%0d gameover", i), oGameOver, tbl[i].go);
         chk($sformatf("row%0d special", i),  oSpecial_block, tbl[i].sp);
         chk($sformatf("row%0d commits", i),  n_commit, tbl[i].commits);
         chk($sformatf("row%0d rst_low", i),  n_low, tbl[i].lows);
      end

      // commit cycle: level, slider and oRST change together, oCommit is one cycle
      drive(1, 0, 0, 0, 0);
      wait_commit(seen);
      chk("seqA commit seen", seen, 1);
      chk("seqA level",  oLevel, 1);
      chk("seqA slider", oSlider_flag, 3);
      chk("seqA orst",   oRST, 0);
      @(negedge iCLK);
      chk("seqA commit width", oCommit, 0);
      chk("seqA orst still low", oRST, 0);
      drive(0, 0, 0, 0, 0);
      tick(30);

      // attack stays until a commit; attack and commit together leaves the block set
      drive(0, 0, 0, 0, 1);
      @(negedge iCLK);
      drive(0, 0, 0, 0, 0);
      chk("seqD attacked", oSpecial_block, 0);
      tick(3);
      chk("seqD still attacked", oSpecial_block, 0);
      drive(0, 0, 1, 0, 0);
      repeat (7) @(negedge iCLK);
      iSpecial_attacked = 1'b1;
      @(negedge iCLK);
      chk("seqD commit timing", oCommit, 1);
      chk("seqD commit wins", oSpecial_block, 1);
      chk("seqD level", oLevel, 2);
      drive(0, 0, 0, 0, 0);
      tick(30);
      chk("seqD special after", oSpecial_block, 1);

      // reset during the second low cycle of a pulse
      drive(0, 1, 0, 0, 0);
      wait_commit(seen);
      chk("seqB commit seen", seen, 1);
      chk("seqB level at commit", oLevel, 1);
      @(negedge iCLK);
      chk("seqB in pulse", oRST, 0);
      iRST = 1'b0;
      drive(0, 0, 0, 0, 0);
      #1;
      chk("seqB orst",   oRST, 1);
      chk("seqB level",  oLevel, 0);
      chk("seqB lives",  oLives, 3);
      chk("seqB commit", oCommit, 0);
      @(negedge iCLK);
      iRST = 1'b1;
      n_commit = 0;
      tick(30);
      chk("seqB quiet after", n_commit, 0);
      chk("seqB level after", oLevel, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
